// File: rtl/fixed_bcd_formatter.sv
// rtl/fixed_bcd_formatter.sv - signed Q18.14 to sign + packed BCD integer/fraction digits
module fixed_bcd_formatter #(
  parameter int FRAC_BITS   = 14,
  parameter int INT_DIGITS  = 6,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              value,
  input  logic                     in_error,
  output logic                     busy,
  output logic                     done,
  output logic                     sign,
  output logic [4*INT_DIGITS-1:0]  int_bcd,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output logic [2:0]               int_ndigits,
  output logic                     error
);

  localparam int IB      = 32 - FRAC_BITS;
  localparam int IW      = 4 * INT_DIGITS;
  localparam int FW      = 4 * FRAC_DIGITS;
  localparam int CNT_MAX = (IB > FRAC_DIGITS) ? IB : FRAC_DIGITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(IB - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FRAC_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INT,
    S_FRAC
  } state_t;

  // Working registers (conversion in flight)
  state_t               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [IB-1:0]        int_sh_q,   int_sh_d;
  logic [FRAC_BITS-1:0] frac_q,     frac_d;
  logic [IW-1:0]        bcd_q,      bcd_d;
  logic [FW-1:0]        frac_acc_q, frac_acc_d;
  logic                 sign_w_q,   sign_w_d;
  logic                 err_w_q,    err_w_d;

  // Visible output registers (only updated on completion)
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 sign_q,     sign_d;
  logic [IW-1:0]        int_bcd_q,  int_bcd_d;
  logic [FW-1:0]        frac_bcd_q, frac_bcd_d;
  logic [2:0]           int_nd_q,   int_nd_d;
  logic                 error_q,    error_d;

  // Combinational helpers
  logic [31:0]          mag;
  logic [IW-1:0]        bcd_adj;
  logic [FRAC_BITS+3:0] frac_x10;
  logic [3:0]           frac_digit;
  logic [2:0]           ndigits;

  // Datapath helpers: magnitude, double-dabble adjust, x10 step, digit count
  always_comb begin
    mag = value[31] ? (~value + 32'd1) : value;

    bcd_adj = '0;
    for (int i = 0; i < INT_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end

    // f*10 computed as f*8 + f*2; the top nibble is the next decimal digit
    frac_x10   = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);
    frac_digit = frac_x10[FRAC_BITS+3:FRAC_BITS];

    ndigits = 3'd1;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        ndigits = 3'(i + 1);
      end
    end
  end

  // FSM next-state and datapath/output next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_sh_d   = int_sh_q;
    frac_d     = frac_q;
    bcd_d      = bcd_q;
    frac_acc_d = frac_acc_q;
    sign_w_d   = sign_w_q;
    err_w_d    = err_w_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sign_d     = sign_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    int_nd_d   = int_nd_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // An errored result is presented as an unsigned zero
          if (in_error) begin
            int_sh_d = '0;
            frac_d   = '0;
            sign_w_d = 1'b0;
          end else begin
            int_sh_d = mag[31:FRAC_BITS];
            frac_d   = mag[FRAC_BITS-1:0];
            sign_w_d = value[31];
          end
          err_w_d    = in_error;
          bcd_d      = '0;
          frac_acc_d = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_INT;
        end
      end

      S_INT: begin
        // Double-dabble: adjust then shift in the next integer bit, MSB first
        bcd_d    = (bcd_adj << 1) | {{(IW-1){1'b0}}, int_sh_q[IB-1]};
        int_sh_d = int_sh_q << 1;
        if (cnt_q == INT_LAST) begin
          cnt_d   = '0;
          state_d = S_FRAC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FRAC: begin
        frac_d = frac_x10[FRAC_BITS-1:0];
        // Digit k lands in nibble k counted from the top
        for (int i = 0; i < FRAC_DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            frac_acc_d[4*(FRAC_DIGITS-1-i) +: 4] = frac_digit;
          end
        end
        if (cnt_q == FRAC_LAST) begin
          // Publish the complete result in one step
          sign_d     = sign_w_q;
          error_d    = err_w_q;
          int_bcd_d  = bcd_q;
          frac_bcd_d = frac_acc_d;
          int_nd_d   = ndigits;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      int_sh_q   <= '0;
      frac_q     <= '0;
      bcd_q      <= '0;
      frac_acc_q <= '0;
      sign_w_q   <= 1'b0;
      err_w_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      int_nd_q   <= 3'd1;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_sh_q   <= int_sh_d;
      frac_q     <= frac_d;
      bcd_q      <= bcd_d;
      frac_acc_q <= frac_acc_d;
      sign_w_q   <= sign_w_d;
      err_w_q    <= err_w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sign_q     <= sign_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      int_nd_q   <= int_nd_d;
      error_q    <= error_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sign        = sign_q;
  assign int_bcd     = int_bcd_q;
  assign frac_bcd    = frac_bcd_q;
  assign int_ndigits = int_nd_q;
  assign error       = error_q;

endmodule

// File: tb/tb_fixed_bcd_formatter.sv
// tb/tb_fixed_bcd_formatter.sv - randomized and directed bench for fixed_bcd_formatter
module tb_fixed_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        in_error = 1'b0;
  logic        busy;
  logic        done;
  logic        sign;
  logic [23:0] int_bcd;
  logic [15:0] frac_bcd;
  logic [2:0]  int_ndigits;
  logic        error;

  int total = 0;
  int bad = 0;

  fixed_bcd_formatter dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .in_error    (in_error),
    .busy        (busy),
    .done        (done),
    .sign        (sign),
    .int_bcd     (int_bcd),
    .frac_bcd    (frac_bcd),
    .int_ndigits (int_ndigits),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Reference: {sign, error, ndigits, int_bcd, frac_bcd} from decimal arithmetic
  function automatic logic [44:0] model(input logic [31:0] v, input logic e);
    longint m, ip, fr, fv, p;
    logic [23:0] ib;
    logic [15:0] fb;
    logic [2:0]  nd;
    logic        s;
    m = longint'(signed'(v));
    s = (m < 0);
    if (m < 0) m = -m;
    if (e) begin
      m = 0;
      s = 1'b0;
    end
    ip = m / 16384;
    fr = m % 16384;
    fv = (fr * 10000) / 16384;
    nd = 3'd1;
    p = 10;
    for (int k = 2; k <= 6; k++) begin
      if (ip >= p) nd = 3'(k);
      p = p * 10;
    end
    ib = '0;
    for (int i = 0; i < 6; i++) begin
      ib[4*i +: 4] = 4'(ip % 10);
      ip = ip / 10;
    end
    fb = '0;
    for (int i = 0; i < 4; i++) begin
      fb[4*i +: 4] = 4'(fv % 10);
      fv = fv / 10;
    end
    return {s, e, nd, ib, fb};
  endfunction

  // Issue one start and wait for done; cyc = clocks from accepting edge to done, -1 on timeout
  task automatic convert(input logic [31:0] v, input logic e, output int cyc);
    @(negedge clk);
    value = v;
    in_error = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = ~v;
    in_error = ~e;
    cyc = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, sign, int_bcd, frac_bcd, int_ndigits, error} !== {1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b sign=%b int=%h frac=%h nd=%0d err=%b want 0 0 0 000000 0000 1 0",
               busy, done, sign, int_bcd, frac_bcd, int_ndigits, error);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] tv [7] = '{32'h0000_4000, 32'hFFFF_6000, 32'h0000_1555, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'hFFFF_C000, 32'h000A_8000};
    logic        te [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ts [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [23:0] ti [7] = '{24'h000001, 24'h000002, 24'h000000, 24'h131071,
                            24'h131072, 24'h000000, 24'h000042};
    logic [15:0] tf [7] = '{16'h0000, 16'h5000, 16'h3333, 16'h9999,
                            16'h0000, 16'h0000, 16'h0000};
    logic [2:0]  tn [7] = '{3'd1, 3'd1, 3'd1, 3'd6, 3'd6, 3'd1, 3'd2};
    int cyc;
    for (int k = 0; k < 7; k++) begin
      convert(tv[k], te[k], cyc);
      total++;
      if (cyc !== 22) begin
        bad++;
        $display("FAIL directed_latency v=%h got %0d want 22", tv[k], cyc);
      end
      total++;
      if ({sign, error, int_bcd, frac_bcd, int_ndigits} !== {ts[k], te[k], ti[k], tf[k], tn[k]}) begin
        bad++;
        $display("FAIL directed_value v=%h e=%b got sign=%b err=%b int=%h frac=%h nd=%0d want sign=%b err=%b int=%h frac=%h nd=%0d",
                 tv[k], te[k], sign, error, int_bcd, frac_bcd, int_ndigits, ts[k], te[k], ti[k], tf[k], tn[k]);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL directed_busy_at_done v=%h got %b want 0", tv[k], busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic        e;
    logic [44:0] exp;
    int cyc;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 32'h0003_FFFF);
        2:       v = -$urandom_range(0, 32'h0003_FFFF);
        default: v = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom)};
      endcase
      e = ($urandom_range(0, 7) == 0);
      exp = model(v, e);
      convert(v, e, cyc);
      total++;
      if (cyc !== 22) begin
        bad++;
        $display("FAIL random_latency v=%h got %0d want 22", v, cyc);
      end
      total++;
      if ({sign, error, int_ndigits, int_bcd, frac_bcd} !== exp) begin
        bad++;
        $display("FAIL random_value v=%h e=%b got %h want %h", v, e,
                 {sign, error, int_ndigits, int_bcd, frac_bcd}, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] v1 = 32'hFFE1_2345;
    logic [31:0] v2 = 32'h0001_0000;
    logic [44:0] prev, exp;
    int ndone = 0;
    int first = -1;
    prev = {sign, error, int_ndigits, int_bcd, frac_bcd};
    exp = model(v1, 1'b0);
    @(negedge clk);
    value = v1;
    in_error = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_mid_conversion got %b want 1", busy);
        end
        value = v2;
        start = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (n == 12) begin
        total++;
        if ({sign, error, int_ndigits, int_bcd, frac_bcd} !== prev) begin
          bad++;
          $display("FAIL outputs_hold got %h want %h", {sign, error, int_ndigits, int_bcd, frac_bcd}, prev);
        end
      end
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    total++;
    if (ndone !== 1 || first !== 22) begin
      bad++;
      $display("FAIL ignored_start_dones got count=%0d at=%0d want count=1 at=22", ndone, first);
    end
    total++;
    if ({sign, error, int_ndigits, int_bcd, frac_bcd} !== exp) begin
      bad++;
      $display("FAIL ignored_start_value got %h want %h", {sign, error, int_ndigits, int_bcd, frac_bcd}, exp);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [44:0] exp;
    convert(32'h0000_6000, 1'b0, c1);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done got %b want 1", done);
    end
    exp = model(32'h8765_4321, 1'b0);
    convert(32'h8765_4321, 1'b0, c2);
    total++;
    if (c1 !== 22 || c2 !== 22) begin
      bad++;
      $display("FAIL b2b_latency got %0d,%0d want 22,22", c1, c2);
    end
    total++;
    if ({sign, error, int_ndigits, int_bcd, frac_bcd} !== exp) begin
      bad++;
      $display("FAIL b2b_value got %h want %h", {sign, error, int_ndigits, int_bcd, frac_bcd}, exp);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle got %b want 0", done);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int cyc;
    @(negedge clk);
    value = 32'h0012_3456;
    in_error = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, sign, int_bcd, frac_bcd, int_ndigits, error} !== {1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b sign=%b int=%h frac=%h nd=%0d err=%b want 0 0 0 000000 0000 1 0",
               busy, done, sign, int_bcd, frac_bcd, int_ndigits, error);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done got %0d active cycles want 0", ndone);
    end
    convert(32'hFFFF_6000, 1'b0, cyc);
    total++;
    if (cyc !== 22 || {sign, int_bcd, frac_bcd} !== {1'b1, 24'h000002, 16'h5000}) begin
      bad++;
      $display("FAIL after_reset_conv got cyc=%0d sign=%b int=%h frac=%h want 22 1 000002 5000",
               cyc, sign, int_bcd, frac_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
